fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Fetch sequencer between the program counter and the 1024B instruction memory.
//  Owns pc_out and issues one-outstanding-request fetches over a req/ready + rvalid handshake.
//  Holds the fetched word for decode, and applies branch/jal/jalr redirects from execute.
//  Squashes any in-flight or held wrong-path fetch when a redirect lands.
// PARAMETERS
//  ADDR_W    10   byte-address width of instruction memory (2^ADDR_W bytes)
//  IMM_W     21   immediate width (J-type maximum)
//  RESET_PC  0    pc_out value after reset
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       asynchronous, active-low reset
//  imem_req       out  1       fetch request valid
//  imem_addr      out  ADDR_W  fetch byte address (= pc_out)
//  imem_ready     in   1       memory accepts request this cycle
//  imem_rvalid    in   1       read data valid (exactly one per accepted request)
//  imem_rdata     in   32      instruction word
//  instr_valid    out  1       instruction held for decode
//  instr          out  32      held instruction
//  instr_pc       out  ADDR_W  address of held instruction
//  dec_ready      in   1       decode consumes held instruction
//  redirect_valid in   1       execute reports a control-flow instruction
//  redirect_sel   in   2       01=branch, 10=jal, 11=jalr, 00=ignored
//  zero_flag      in   1       branch condition true
//  redirect_base  in   ADDR_W  PC of the control-flow instruction
//  immediate      in   IMM_W   sign-extended offset
//  reg_out1       in   32      Reg[rs1] (jalr base)
//  pc_out         out  ADDR_W  current fetch PC
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, pc_out=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0.
//  States:
//   IDLE  -> REQ on the first clock after reset deasserts.
//   REQ   imem_req=1, imem_addr=pc_out; -> WAIT when imem_ready.
//   WAIT  -> OUT on imem_rvalid: latch instr=imem_rdata, instr_pc=pc_out.
//   OUT   instr_valid=1; on dec_ready: pc_out+=4, -> REQ.
//   DRAIN wait for imem_rvalid, discard the data, -> REQ.
//  Taken redirect = redirect_valid & (sel==10 | sel==11 | (sel==01 & zero_flag)).
//   sel=01 with zero_flag=0 is a no-op.
//  Redirect target:
//   branch/jal: redirect_base + sext(immediate).
//   jalr: (reg_out1 + sext(immediate)) & ~1.
//   Result truncated to ADDR_W.
//  Taken redirect, action by state:
//   REQ: pc_out<=target; stays REQ. A request accepted in the same cycle goes to DRAIN.
//   WAIT: pc_out<=target, -> DRAIN. If imem_rvalid in the same cycle: data discarded, -> REQ.
//   OUT: instr_valid drops next cycle, pc_out<=target, -> REQ. Coincident dec_ready is an
//        accepted handoff; the redirect still wins pc_out.
//   IDLE/DRAIN: pc_out<=target; DRAIN still waits for its response.
//  Redirect has priority over sequential +4 in every state; no instruction from the
//   wrong path is ever presented with instr_valid=1.
//  Wrap: pc_out+4 modulo 2^ADDR_W (1020 -> 0 for ADDR_W=10).
//  Latency: redirect to imem_req at target = 1 clk (from OUT/REQ/WAIT+rvalid).
//   Fetch to instr_valid = rvalid cycle + 1.
//  Reset mid-operation aborts all states. An imem_rvalid arriving in IDLE is ignored.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   - Adds output misalign_err (1 bit, reset 0).
//   - A taken redirect with target[1:0]!=0 pulses misalign_err for 1 clk, enters HALT
//     (imem_req=0, instr_valid=0), and stays in HALT until reset.
//  MISALIGN_TRAP_EN undefined: target[1:0] forced to 2'b00; no HALT state, no port.
// STRUCTURE
//  Shared package riscv_pkg holds:
//   - FSM state encoding (IDLE, REQ, WAIT, OUT, DRAIN, HALT).
//   - redirect_sel encodings (SEL_BR, SEL_JAL, SEL_JALR).
//   - ILEN=32 and PC_INC=4.
//  Sub-module fetch_tgt_calc: combinational taken decode and target calculation
//   (sign extension, jalr bit-0 clear, truncation, misalign flag).
// TESTING
//  - Reset release, memory ready=1, 1-cycle rvalid, dec_ready=1: imem_addr sequence 0,4,8,...
//    instr_pc matches; addr 1020 -> 0 wrap.
//  - Branch sel=01, zero_flag=1, base=8, imm=-8 while in OUT: next imem_addr=0,
//    held instr dropped.
//  - Branch sel=01, zero_flag=0: no redirect; addresses continue +4.
//  - jalr reg_out1=0x101, imm=4 during WAIT: response discarded (DRAIN), next
//    imem_addr=0x104; the same redirect coincident with rvalid goes straight to REQ.
//  - dec_ready=0 for 5 clks: instr/instr_pc stable, no new imem_req;
//    reset asserted mid-WAIT: outputs at reset values asynchronously.
//  - MISALIGN_TRAP_EN, jal to base 0 imm=6: misalign_err 1-clk pulse, HALT, imem_req=0;
//    without the macro the next imem_addr=4.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: FSM encoding, redirect selects, instruction constants.
package riscv_pkg;

    localparam int ILEN   = 32;
    localparam int PC_INC = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        DRAIN = 3'd4,
        HALT  = 3'd5
    } fetch_state_t;

    localparam logic [1:0] SEL_BR   = 2'b01;
    localparam logic [1:0] SEL_JAL  = 2'b10;
    localparam logic [1:0] SEL_JALR = 2'b11;

endpackage

// File: rtl/fetch_tgt_calc.sv
// Purpose: taken decode and redirect target (sext, jalr bit-0 clear, truncation); MISALIGN_TRAP_EN adds misalign flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle from execute-stage inputs.
module fetch_tgt_calc
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int IMM_W  = 21
) (
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_sel,
    input  logic              zero_flag,
    input  logic [ADDR_W-1:0] redirect_base,
    input  logic [IMM_W-1:0]  immediate,
    input  logic [ILEN-1:0]   reg_out1,
`ifdef MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    output logic              taken,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] raw;
    logic [ADDR_W-1:0] imm_lo;

    // Only the low ADDR_W bits survive truncation, so the sum is done at that width.
    assign imm_lo = immediate[ADDR_W-1:0];

    always_comb begin
        taken = 1'b0;
        if (redirect_valid) begin
            case (redirect_sel)
                SEL_BR:   taken = zero_flag;
                SEL_JAL:  taken = 1'b1;
                SEL_JALR: taken = 1'b1;
                default:  taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        raw = redirect_base + imm_lo;
        if (redirect_sel == SEL_JALR) begin
            raw    = reg_out1[ADDR_W-1:0] + imm_lo;
            raw[0] = 1'b0;
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign target   = raw;
    assign misalign = |raw[1:0];
    logic unused_hi;
    assign unused_hi = ^{reg_out1[ILEN-1:ADDR_W], immediate[IMM_W-1:ADDR_W]};
`else
    assign target = {raw[ADDR_W-1:2], 2'b00};
    logic unused_hi;
    assign unused_hi = ^{reg_out1[ILEN-1:ADDR_W], immediate[IMM_W-1:ADDR_W], raw[1:0]};
`endif

endmodule

// File: rtl/fetch_ctrl.sv
// Purpose: fetch sequencer owning pc_out, one outstanding imem request, redirect/squash; MISALIGN_TRAP_EN adds trap+HALT.
// Latency: rvalid to instr_valid 1 clk; taken redirect to imem_req at target 1 clk.
// Backpressure: imem_ready stalls REQ; dec_ready=0 holds instr in OUT with no new request.
module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter int                IMM_W    = 21,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [ILEN-1:0]   imem_rdata,
    output logic              instr_valid,
    output logic [ILEN-1:0]   instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              dec_ready,
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_sel,
    input  logic              zero_flag,
    input  logic [ADDR_W-1:0] redirect_base,
    input  logic [IMM_W-1:0]  immediate,
    input  logic [ILEN-1:0]   reg_out1,
`ifdef MISALIGN_TRAP_EN
    output logic              misalign_err,
`endif
    output logic [ADDR_W-1:0] pc_out
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ILEN-1:0]   instr_nxt;
    logic [ADDR_W-1:0] instr_pc_nxt;
    logic              taken;
    logic [ADDR_W-1:0] target;

`ifdef MISALIGN_TRAP_EN
    logic misalign;
    logic err_nxt;
`endif

    fetch_tgt_calc #(
        .ADDR_W (ADDR_W),
        .IMM_W  (IMM_W)
    ) u_tgt (
        .redirect_valid (redirect_valid),
        .redirect_sel   (redirect_sel),
        .zero_flag      (zero_flag),
        .redirect_base  (redirect_base),
        .immediate      (immediate),
        .reg_out1       (reg_out1),
`ifdef MISALIGN_TRAP_EN
        .misalign       (misalign),
`endif
        .taken          (taken),
        .target         (target)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pc_out   <= RESET_PC;
            instr    <= '0;
            instr_pc <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            pc_out   <= pc_nxt;
            instr    <= instr_nxt;
            instr_pc <= instr_pc_nxt;
`ifdef MISALIGN_TRAP_EN
            misalign_err <= err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_out;
        instr_nxt    = instr;
        instr_pc_nxt = instr_pc;
        case (state)
            IDLE: begin
                state_nxt = REQ;
                if (taken) pc_nxt = target;
            end
            REQ: begin
                // An accepted request racing a redirect is wrong-path: drain its response.
                if (taken) begin
                    pc_nxt    = target;
                    state_nxt = imem_ready ? DRAIN : REQ;
                end else if (imem_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (taken) begin
                        pc_nxt    = target;
                        state_nxt = REQ;
                    end else begin
                        instr_nxt    = imem_rdata;
                        instr_pc_nxt = pc_out;
                        state_nxt    = OUT;
                    end
                end else if (taken) begin
                    pc_nxt    = target;
                    state_nxt = DRAIN;
                end
            end
            OUT: begin
                if (taken) begin
                    pc_nxt    = target;
                    state_nxt = REQ;
                end else if (dec_ready) begin
                    pc_nxt    = pc_out + ADDR_W'(PC_INC);
                    state_nxt = REQ;
                end
            end
            DRAIN: begin
                if (taken) pc_nxt = target;
                if (imem_rvalid) state_nxt = REQ;
            end
            default: state_nxt = state;
        endcase
`ifdef MISALIGN_TRAP_EN
        err_nxt = 1'b0;
        if (taken && misalign && state != HALT) begin
            state_nxt = HALT;
            pc_nxt    = pc_out;
            err_nxt   = 1'b1;
        end
`endif
    end

    assign imem_req    = (state == REQ);
    assign imem_addr   = pc_out;
    assign instr_valid = (state == OUT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl: expected fetch PCs queued at stimulus, checked at decode handoff.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [9:0]  instr_pc;
    logic        dec_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [1:0]  redirect_sel = 2'b00;
    logic        zero_flag = 1'b0;
    logic [9:0]  redirect_base = '0;
    logic [20:0] immediate = '0;
    logic [31:0] reg_out1 = '0;
    logic [9:0]  pc_out;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int ncmp  = 0;
    int nfail = 0;
    logic [9:0] exp_q[$];
    logic [9:0] pend_q[$];
    bit mem_hold = 1'b0;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .dec_ready      (dec_ready),
        .redirect_valid (redirect_valid),
        .redirect_sel   (redirect_sel),
        .zero_flag      (zero_flag),
        .redirect_base  (redirect_base),
        .immediate      (immediate),
        .reg_out1       (reg_out1),
`ifdef MISALIGN_TRAP_EN
        .misalign_err   (misalign_err),
`endif
        .pc_out         (pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return {16'hC0DE, 6'd0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard the decode handoff, advance, then play the memory side.
    task automatic tick();
        logic       acc;
        logic [9:0] a;
        logic [9:0] e;
        acc = imem_req && imem_ready;
        a   = imem_addr;
        if (instr_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
                ncmp++;
                nfail++;
                $error("FAIL unexpected_instr: observed pc %h expected no handoff", instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk("instr_pc", 32'(instr_pc), 32'(e));
                chk("instr", instr, mem_word(e));
            end
        end
        @(posedge clk);
        #1;
        if (acc) pend_q.push_back(a);
        if (pend_q.size() != 0 && !mem_hold) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    task automatic drain_exp(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        ncmp++;
        assert (exp_q.size() == 0) else begin
            nfail++;
            $error("FAIL %s_timeout: observed %0d pending expected 0", tag, exp_q.size());
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(instr_valid), 32'd1);
    endtask

    task automatic set_redirect(input logic [1:0] sel, input logic z, input logic [9:0] base,
                                input logic [20:0] imm, input logic [31:0] r1);
        redirect_valid = 1'b1;
        redirect_sel   = sel;
        zero_flag      = z;
        redirect_base  = base;
        immediate      = imm;
        reg_out1       = r1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Async reset values
        #1 reset = 1'b0;
        #1;
        chk("rst_pc", 32'(pc_out), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
`ifdef MISALIGN_TRAP_EN
        chk("rst_err", 32'(misalign_err), 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // Sequential fetch
        for (int i = 0; i < 4; i++) exp_q.push_back(10'(i * 4));
        drain_exp("seq");
        chk("seq_req", 32'(imem_req), 32'd1);
        chk("seq_addr", 32'(imem_addr), 32'd16);

        // jal to 1020 while request is not accepted, then wrap
        imem_ready = 1'b0;
        set_redirect(2'b10, 1'b0, 10'd1016, 21'd4, 32'd0);
        tick();
        redirect_valid = 1'b0;
        imem_ready     = 1'b1;
        chk("jal_req", 32'(imem_req), 32'd1);
        chk("jal_addr", 32'(imem_addr), 32'd1020);
        exp_q.push_back(10'd1020);
        exp_q.push_back(10'd0);
        exp_q.push_back(10'd4);
        drain_exp("wrap");

        // Decode stall then taken branch in OUT
        dec_ready = 1'b0;
        wait_valid("stall_valid");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_pc", 32'(instr_pc), 32'd8);
            chk("stall_instr", instr, mem_word(10'd8));
            chk("stall_noreq", 32'(imem_req), 32'd0);
        end
        set_redirect(2'b01, 1'b1, 10'd8, 21'h1FFFF8, 32'd0);
        tick();
        redirect_valid = 1'b0;
        chk("br_drop", 32'(instr_valid), 32'd0);
        chk("br_req", 32'(imem_req), 32'd1);
        chk("br_addr", 32'(imem_addr), 32'd0);
        dec_ready = 1'b1;
        exp_q.push_back(10'd0);
        exp_q.push_back(10'd4);
        drain_exp("br");

        // Not-taken branch held throughout
        set_redirect(2'b01, 1'b0, 10'd8, 21'h1FFFF8, 32'd0);
        exp_q.push_back(10'd8);
        exp_q.push_back(10'd12);
        exp_q.push_back(10'd16);
        drain_exp("nt");
        redirect_valid = 1'b0;
        chk("nt_addr", 32'(imem_addr), 32'd20);

        // jalr during WAIT: drain then target
        mem_hold = 1'b1;
        tick();
        set_redirect(2'b11, 1'b0, 10'd0, 21'd4, 32'h101);
        tick();
        redirect_valid = 1'b0;
        chk("drain_noreq", 32'(imem_req), 32'd0);
        chk("drain_novalid", 32'(instr_valid), 32'd0);
        mem_hold = 1'b0;
        tick();
        tick();
        chk("jalr_req", 32'(imem_req), 32'd1);
        chk("jalr_addr", 32'(imem_addr), 32'h104);
        exp_q.push_back(10'h104);
        drain_exp("jalr");

        // jalr coincident with rvalid: straight to REQ
        tick();
        set_redirect(2'b11, 1'b0, 10'd0, 21'd4, 32'h101);
        tick();
        redirect_valid = 1'b0;
        chk("coin_req", 32'(imem_req), 32'd1);
        chk("coin_addr", 32'(imem_addr), 32'h104);
        chk("coin_novalid", 32'(instr_valid), 32'd0);
        exp_q.push_back(10'h104);
        exp_q.push_back(10'h108);
        drain_exp("coin");

        // Reset mid-WAIT, then rvalid arriving in IDLE is ignored
        mem_hold = 1'b1;
        tick();
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_pc", 32'(pc_out), 32'd0);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_instr", instr, 32'd0);
        chk("mid_rst_instr_pc", 32'(instr_pc), 32'd0);
        pend_q.delete();
        mem_hold    = 1'b0;
        imem_rvalid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        chk("idle_rv_req", 32'(imem_req), 32'd1);
        chk("idle_rv_addr", 32'(imem_addr), 32'd0);
        chk("idle_rv_valid", 32'(instr_valid), 32'd0);
        exp_q.push_back(10'd0);
        exp_q.push_back(10'd4);
        drain_exp("post_rst");

        // Misaligned jal (base 0, imm 6) from OUT
        dec_ready = 1'b0;
        wait_valid("mis_valid");
        set_redirect(2'b10, 1'b0, 10'd0, 21'd6, 32'd0);
        tick();
        redirect_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
        chk("mis_err", 32'(misalign_err), 32'd1);
        chk("mis_noreq", 32'(imem_req), 32'd0);
        chk("mis_novalid", 32'(instr_valid), 32'd0);
        tick();
        chk("mis_err_pulse", 32'(misalign_err), 32'd0);
        dec_ready = 1'b1;
        repeat (3) tick();
        chk("halt_noreq", 32'(imem_req), 32'd0);
        chk("halt_novalid", 32'(instr_valid), 32'd0);
`else
        chk("mis_req", 32'(imem_req), 32'd1);
        chk("mis_addr", 32'(imem_addr), 32'd4);
        chk("mis_novalid", 32'(instr_valid), 32'd0);
        dec_ready = 1'b1;
        exp_q.push_back(10'd4);
        drain_exp("mis");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
